// File: rtl/debug_clk_div_gen_if.sv
// ----------------------------------------------------------------------------
// debug_clk_div_gen_if
//   Divisor-update request channel for debug_clk_div_gen.
//
//   cfg_valid : divisor-update request
//   cfg_ch    : target channel index
//   cfg_div   : requested divisor
//   cfg_ready : update can be accepted for cfg_ch (combinational)
//
//   master : requester side (drives valid/ch/div, observes ready)
//   slave  : divider side   (observes valid/ch/div, drives ready)
// ----------------------------------------------------------------------------
interface debug_clk_div_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/debug_clk_div_gen.sv
// ----------------------------------------------------------------------------
// debug_clk_div_gen
//   NUM_CH independent programmable clock dividers running off clk_ref.
//   Each channel counts 0..D-1 and produces a registered divided clock
//   (high for ceil(D/2) cycles) and a one-cycle tick at phase 0. Divisor
//   changes are queued as "pending" and only take effect at a period
//   boundary (or immediately for a disabled channel, or on sync), so a
//   running period is never truncated or stretched.
//
//   clk_ref : reference clock, all logic on its rising edge
//   rst_n   : asynchronous active-low reset
//   sync    : one-cycle pulse, realigns enabled channels to phase 0 and
//             applies any already-pending divisors
//   cfg     : divisor-update handshake (slave modport)
//   clk_div : divided clock per channel
//   tick    : one-cycle strobe at the start of each divided period
//   pending : channel holds an accepted, not-yet-applied divisor
// ----------------------------------------------------------------------------
module debug_clk_div_gen #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic                 clk_ref,
    input  logic                 rst_n,
    input  logic                 sync,
    debug_clk_div_gen_if.slave   cfg,
    output logic [NUM_CH-1:0]    clk_div,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    pending
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [DIV_W-1:0] RST_D   = DIV_W'(RESET_DIV);
    // Counter parked at the last phase so the first edge after reset wraps
    // to phase 0 and presents tick/clk_div immediately.
    localparam logic [DIV_W-1:0] RST_CNT = (RESET_DIV >= 2) ? DIV_W'(RESET_DIV - 1) : '0;

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    // Ready only for an existing channel with no divisor already queued;
    // out-of-range indices match no channel and stay not-ready.
    always_comb begin
        cfg.cfg_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(cfg.cfg_ch) == i) begin
                cfg.cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] d_q;
        logic [DIV_W-1:0] d_nxt;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W-1:0] pdiv_q;
        logic [DIV_W-1:0] half_nxt;
        logic             pvld_q;
        logic             clk_q;
        logic             tick_q;
        logic             en_q;
        logic             en_nxt;
        logic             boundary;
        logic             apply;
        logic             accept;
        logic             clk_nxt;
        logic             tick_nxt;

        assign accept = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(g));

        always_comb begin
            en_q     = (d_q > ONE);
            boundary = en_q && (cnt_q == (d_q - ONE));
            // A queued divisor lands at the period boundary, on sync, or at
            // once when the channel is idle. A request accepted in this same
            // cycle is not yet in pvld_q, so sync never applies it.
            apply    = pvld_q && (sync || !en_q || boundary);
            d_nxt    = apply ? pdiv_q : d_q;
            en_nxt   = (d_nxt > ONE);

            if (!en_q || !en_nxt || boundary || sync) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_q + ONE;
            end

            // ceil(D/2) without overflow for D at full scale
            half_nxt = (d_nxt >> 1) + {{(DIV_W-1){1'b0}}, d_nxt[0]};
            clk_nxt  = en_nxt && (cnt_nxt < half_nxt);
            tick_nxt = en_nxt && (cnt_nxt == '0);
        end

        always_ff @(posedge clk_ref or negedge rst_n) begin
            if (!rst_n) begin
                d_q    <= RST_D;
                cnt_q  <= RST_CNT;
                pvld_q <= 1'b0;
                pdiv_q <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                d_q    <= d_nxt;
                cnt_q  <= cnt_nxt;
                clk_q  <= clk_nxt;
                tick_q <= tick_nxt;
                // accept needs pvld_q low and apply needs it high, so the
                // two never coincide.
                if (accept) begin
                    pvld_q <= 1'b1;
                    pdiv_q <= cfg.cfg_div;
                end else if (apply) begin
                    pvld_q <= 1'b0;
                end
            end
        end

        assign clk_div[g] = clk_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pvld_q;
    end

endmodule

// File: tb/tb_debug_clk_div_gen.sv
// ----------------------------------------------------------------------------
// tb_debug_clk_div_gen
//   Directed scoreboard bench for debug_clk_div_gen (4 channels, 8-bit
//   divisors, reset divisor 4). The stimulus process drives one cycle at a
//   time and pushes the expected clk_div/tick/pending/cfg_ready for that
//   cycle; a monitor on the falling edge pops and compares.
//   Expected waveforms come from hand-placed per-channel segments
//   (divisor D starting at phase 0 on edge s), giving cnt = (n-s) mod D.
// ----------------------------------------------------------------------------
module tb_debug_clk_div_gen;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic              clk_ref;
    logic              rst_n;
    logic              sync;
    logic [NUM_CH-1:0] clk_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    debug_clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

    debug_clk_div_gen #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (4)
    ) dut (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .sync    (sync),
        .cfg     (cfg_if),
        .clk_div (clk_div),
        .tick    (tick),
        .pending (pending)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    int cyc = 0;
    always @(posedge clk_ref) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         n;
        logic [3:0] clk;
        logic [3:0] tk;
        logic [3:0] pend;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // expectation state owned by the stimulus process
    int         n;
    int         ch_d [NUM_CH];
    int         ch_s [NUM_CH];
    logic [3:0] exp_pend;

    task automatic set_ch(input int ch, input int d, input int s);
        ch_d[ch] = d;
        ch_s[ch] = s;
    endtask

    task automatic push_expect();
        exp_t e;
        e.cyc  = cyc;
        e.n    = n;
        e.pend = exp_pend;
        e.rdy  = !exp_pend[cfg_if.cfg_ch];
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_d[i] < 2 || n < ch_s[i]) begin
                e.clk[i] = 1'b0;
                e.tk[i]  = 1'b0;
            end else begin
                int p;
                p = (n - ch_s[i]) % ch_d[i];
                e.tk[i]  = (p == 0);
                e.clk[i] = (p < (ch_d[i] + 1) / 2);
            end
        end
        sb.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitor
    exp_t me;

    task automatic cmp(input string f, input int nn, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s n=%0d got %b want %b", f, nn, got, want);
        end
    endtask

    always @(negedge clk_ref) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me = sb.pop_front();
            if (me.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale n=%0d got cycle %0d want cycle %0d", me.n, cyc, me.cyc);
            end else begin
                cmp("clk_div", me.n, clk_div, me.clk);
                cmp("tick",    me.n, tick,    me.tk);
                cmp("pending", me.n, pending, me.pend);
                cmp("cfg_ready", me.n, {3'b000, cfg_if.cfg_ready}, {3'b000, me.rdy});
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        rst_n            = 1'b0;
        sync             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        exp_pend         = '0;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 0, 0);

        // held in reset: everything low, nothing pending
        n = -2;
        @(posedge clk_ref); #1;
        push_expect();
        n = -1;
        @(posedge clk_ref); #1;
        push_expect();

        // release; first edge (n=1) gives phase 0 on every channel
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 4, 1);
        push_expect();

        for (int k = 1; k <= 77; k++) begin
            @(posedge clk_ref); #1;
            n = k;
            cfg_if.cfg_valid = 1'b0;
            sync             = 1'b0;
            case (k)
                // ch1 -> 5 accepted at cnt=1; applies after cnt=3
                10: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd5; end
                11: exp_pend = 4'b0010;
                13: begin set_ch(1, 5, 13); exp_pend = 4'b0000; end
                // ch2 -> 0 (disable at boundary), later -> 6 (applies next edge)
                22: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd0; end
                23: exp_pend = 4'b0100;
                25: begin set_ch(2, 0, 25); exp_pend = 4'b0000; end
                28: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd6; end
                29: exp_pend = 4'b0100;
                30: begin set_ch(2, 6, 30); exp_pend = 4'b0000; end
                // ch0 -> 3; a second ch0 request while pending is refused;
                // ch3 re-requests its current divisor 4 (no phase change)
                40: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd3; end
                41: begin exp_pend = 4'b0001;
                          cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd7; end
                42: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 8'd4; end
                43: exp_pend = 4'b1001;
                45: begin set_ch(0, 3, 45); set_ch(3, 4, 45); exp_pend = 4'b0000; end
                // ch1 -> 2 pending when sync arrives: sync applies it
                53: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd2; end
                54: exp_pend = 4'b0010;
                // sync mid-period with a ch0 request in the same cycle
                55: begin sync = 1'b1;
                          cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd5; end
                56: begin set_ch(0, 3, 56); set_ch(1, 2, 56); set_ch(2, 6, 56); set_ch(3, 4, 56);
                          exp_pend = 4'b0001; end
                59: begin set_ch(0, 5, 59); exp_pend = 4'b0000; end
                // reset pulse while ch0 has a pending divisor
                66: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd3; end
                67: begin rst_n = 1'b0; exp_pend = 4'b0000;
                          for (int i = 0; i < NUM_CH; i++) set_ch(i, 0, 0); end
                68: rst_n = 1'b1;
                69: for (int i = 0; i < NUM_CH; i++) set_ch(i, 4, 69);
                default: ;
            endcase
            push_expect();
        end

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk_ref);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d entries left want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/debug_clk_div_gen.md
DEBUG_CLK_DIV_GEN -- requirements
Module: debug_clk_div_gen

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, number of independent divider channels; DIV_W, default 8, divisor width; RESET_DIV, default 4, divisor loaded into every channel at reset.
REQ-002 Port clk_ref  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port sync  input  1  single-cycle pulse; realigns all enabled channels to phase 0.
REQ-005 Port cfg_valid  input  1  divisor-update request.
REQ-006 Port cfg_ch  input  $clog2(NUM_CH)  target channel index.
REQ-007 Port cfg_div  input  DIV_W  requested divisor.
REQ-008 Port cfg_ready  output  1  update can be accepted for cfg_ch.
REQ-009 Port clk_div  output  NUM_CH  divided clock per channel.
REQ-010 Port tick  output  NUM_CH  one-cycle strobe at the start of each divided period.
REQ-011 Port pending  output  NUM_CH  channel holds an accepted, not-yet-applied divisor.

Function
REQ-012 Each channel SHALL hold an active divisor D, a phase counter cnt (DIV_W bits), an optional pending divisor, and registered clk_div/tick.
REQ-013 A channel with D >= 2 SHALL be enabled; D = 0 or 1 SHALL disable it: cnt = 0, clk_div = 0, tick = 0.
REQ-014 An enabled channel SHALL count cnt 0,1,...,D-1, then wrap to 0, once per clk_ref cycle.
REQ-015 An enabled channel SHALL have, every cycle, clk_div = (cnt < ceil(D/2)) and tick = (cnt == 0); outputs are registered from next-state and never glitch.
REQ-016 Even D SHALL give a 50% duty cycle; odd D SHALL give ceil(D/2) cycles high and floor(D/2) cycles low.
REQ-017 cfg_ready SHALL be combinational: cfg_ready = !pending[cfg_ch]; cfg_ch >= NUM_CH SHALL give cfg_ready = 0 and the request SHALL be ignored.
REQ-018 A handshake (cfg_valid & cfg_ready) SHALL store cfg_div as pending for cfg_ch; pending[cfg_ch] SHALL rise the next cycle.
REQ-019 For an enabled channel, a pending divisor SHALL become D in the cycle where cnt == D-1, so the next cycle starts with cnt = 0 under the new D; the current period is never truncated or stretched.
REQ-020 For a disabled channel, a pending divisor SHALL apply on the next edge; if the new D >= 2, cnt = 0, tick = 1 and clk_div = 1 on the following cycle.
REQ-021 pending SHALL clear in the same edge that applies the divisor; a new request for that channel SHALL be accepted no earlier than the following cycle.
REQ-022 Applying a new D < 2 at a period boundary SHALL force clk_div = 0 and tick = 0 from the next cycle.
REQ-023 sync = 1 SHALL force cnt = 0 on every enabled channel at the next edge (tick = 1, clk_div = 1), and any pending divisors SHALL be applied at that same edge.
REQ-024 A handshake in the same cycle as sync SHALL be accepted into pending and SHALL NOT be applied by that sync; it applies at the next boundary.
REQ-025 A request whose cfg_div equals the current D SHALL still go through the pending/apply sequence with no phase disturbance.
REQ-026 Channels SHALL be fully independent, except for sync.

Reset
REQ-027 While rst_n = 0: D = RESET_DIV, pending = 0, clk_div = 0, tick = 0, and cnt = RESET_DIV-1 (0 if RESET_DIV < 2).
REQ-028 On the first edge after rst_n rises, every channel with RESET_DIV >= 2 SHALL present cnt = 0, tick = 1 and clk_div = 1.
REQ-029 Asserting rst_n mid-period SHALL immediately return all state to REQ-027 values and discard pending divisors.

Verification
REQ-030 Reset release, defaults: tick on all channels in cycles 1, 5, 9, ...; clk_div pattern 1,1,0,0 repeating.
REQ-031 Ch1 cfg_div = 5 accepted at cnt = 1: the current 4-cycle period completes, then tick every 5 cycles with clk_div 1,1,1,0,0; pending[1] high from the accept cycle+1 until the apply edge.
REQ-032 Ch2 cfg_div = 0 accepted, then cfg_div = 6 later: clk_div/tick held 0 after the boundary; one cycle after the second accept tick = 1, then period 6 with duty 3/3.
REQ-033 Back-to-back requests to ch0 while pending: cfg_ready = 0 for ch0 but 1 for ch3 in the same cycle; the ch3 request is accepted, the ch0 request is not.
REQ-034 Channels at D = 3 and D = 4, sync pulsed mid-period with a ch0 request in the same cycle: both channels show tick = 1 on the next cycle, and the ch0 divisor applies at its next natural boundary.
REQ-035 rst_n pulsed low for one cycle while pending[0] = 1: pending clears asynchronously, outputs go to 0, and the REQ-030 sequence restarts.
